// File: rtl/aes_pkg.sv
// Shared types and constants for the AES round controller.
package aes_pkg;

    typedef enum logic [2:0] {
        IDLE,
        INIT,
        ROUND,
        FINAL,
        DONE
    } state_e;

    localparam logic MODE_ENC = 1'b0;
    localparam logic MODE_DEC = 1'b1;

    localparam int NR_128    = 10;
    localparam int NR_192    = 12;
    localparam int NR_256    = 14;
    localparam int KEY_IDX_W = 4;

endpackage

// File: rtl/aes_round_counter.sv
// Round counter: synchronous clear, enable-gated increment, terminal count at NR-1.
module aes_round_counter
    import aes_pkg::*;
#(
    parameter int NR = NR_128
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clr,
    input  logic                 en,
    output logic [KEY_IDX_W-1:0] cnt_q,
    output logic                 tc
);

    localparam logic [KEY_IDX_W-1:0] NR_M1 = KEY_IDX_W'(NR - 1);

    logic [KEY_IDX_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // tc flags the last middle round, so the next step lands on FINAL
    always_comb begin
        tc = (cnt_q == NR_M1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/aes_round_sequencer.sv
// AES round controller: sequences INIT, NR-1 middle rounds and FINAL from one Start,
// producing key indices, direction enables, phase strobes and a Done pulse.
module aes_round_sequencer
    import aes_pkg::*;
#(
    parameter int NR = NR_128
) (
    input  logic       Clk,
    input  logic       Rst,
    input  logic       Start,
    input  logic       Mode,
    input  logic       Hold,
    output logic       EncEn,
    output logic       DecEn,
    output logic [3:0] SelKeyEnc,
    output logic [3:0] SelKeyDec,
    output logic       RoundFirst,
    output logic       RoundLast,
    output logic       Busy,
    output logic       Done
);

    if (!(NR == NR_128 || NR == NR_192 || NR == NR_256)) begin : g_bad_nr
        $fatal(1, "aes_round_sequencer: NR must be 10, 12 or 14");
    end

    localparam logic [KEY_IDX_W-1:0] NR_W = KEY_IDX_W'(NR);

    state_e               state_q, state_d;
    logic                 mode_q, mode_d;
    logic                 cnt_clr, cnt_en, cnt_tc;
    logic [KEY_IDX_W-1:0] cnt_q;
    logic                 accept;

    aes_round_counter #(.NR(NR)) u_round_counter (
        .clk   (Clk),
        .rst   (Rst),
        .clr   (cnt_clr),
        .en    (cnt_en),
        .cnt_q (cnt_q),
        .tc    (cnt_tc)
    );

    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        cnt_clr = 1'b0;
        cnt_en  = 1'b0;
        accept  = Start && (state_q == IDLE || state_q == DONE);
        if (accept) begin
            mode_d  = Mode;
            cnt_clr = 1'b1;
        end
        case (state_q)
            IDLE:  if (accept) state_d = INIT;
            INIT: begin
                cnt_en = !Hold;
                if (!Hold) state_d = ROUND;
            end
            ROUND: begin
                cnt_en = !Hold;
                if (!Hold && cnt_tc) state_d = FINAL;
            end
            // Counter parks at NR through FINAL; it is cleared on the next Start
            FINAL: if (!Hold) state_d = DONE;
            DONE:  state_d = accept ? INIT : IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state_q <= IDLE;
            mode_q  <= MODE_ENC;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
        end
    end

    // Outputs decode only registered state, so Hold/Start never reach them combinationally
    always_comb begin
        Busy       = (state_q == INIT) || (state_q == ROUND) || (state_q == FINAL);
        RoundFirst = (state_q == INIT);
        RoundLast  = (state_q == FINAL);
        Done       = (state_q == DONE);
        EncEn      = Busy && (mode_q == MODE_ENC);
        DecEn      = Busy && (mode_q == MODE_DEC);
        SelKeyEnc  = '0;
        SelKeyDec  = '0;
        if (Busy) begin
            SelKeyEnc = cnt_q;
            SelKeyDec = NR_W - cnt_q;
        end
    end

endmodule

// File: tb/tb_aes_round_sequencer.sv
// Directed bench: per-cycle vector table on an NR=10 instance, plus reset and NR=14 sequences.
module tb_aes_round_sequencer;

    logic       Clk = 1'b0;
    logic       Rst = 1'b1;
    logic       Start = 1'b0;
    logic       Mode = 1'b0;
    logic       Hold = 1'b0;

    logic       enc10, dec10, first10, last10, busy10, done10;
    logic [3:0] se10, sd10;
    logic       enc14, dec14, first14, last14, busy14, done14;
    logic [3:0] se14, sd14;

    int checks = 0;
    int failures = 0;

    always #5 Clk = ~Clk;

    aes_round_sequencer #(.NR(10)) dut10 (
        .Clk(Clk), .Rst(Rst), .Start(Start), .Mode(Mode), .Hold(Hold),
        .EncEn(enc10), .DecEn(dec10), .SelKeyEnc(se10), .SelKeyDec(sd10),
        .RoundFirst(first10), .RoundLast(last10), .Busy(busy10), .Done(done10)
    );

    aes_round_sequencer #(.NR(14)) dut14 (
        .Clk(Clk), .Rst(Rst), .Start(Start), .Mode(Mode), .Hold(Hold),
        .EncEn(enc14), .DecEn(dec14), .SelKeyEnc(se14), .SelKeyDec(sd14),
        .RoundFirst(first14), .RoundLast(last14), .Busy(busy14), .Done(done14)
    );

    // Packed view: {EncEn, DecEn, SelKeyEnc, SelKeyDec, RoundFirst, RoundLast, Busy, Done}
    function automatic logic [13:0] out10();
        return {enc10, dec10, se10, sd10, first10, last10, busy10, done10};
    endfunction

    function automatic logic [13:0] out14();
        return {enc14, dec14, se14, sd14, first14, last14, busy14, done14};
    endfunction

    // Expected outputs while busy at round k of an NR-round operation in direction m
    function automatic logic [13:0] exp_busy(int k, bit m, int nr);
        logic [3:0] se;
        logic [3:0] sd;
        se = 4'(k);
        sd = 4'(nr - k);
        return {~m, m, se, sd, (k == 0), (k == nr), 1'b1, 1'b0};
    endfunction

    localparam logic [13:0] EXP_DONE = 14'h0001;
    localparam logic [13:0] EXP_IDLE = 14'h0000;

    typedef struct {
        bit          start;
        bit          mode;
        bit          hold;
        logic [13:0] exp;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input bit s, input bit m, input bit h, input logic [13:0] e);
        vec_t v;
        v.start = s;
        v.mode  = m;
        v.hold  = h;
        v.exp   = e;
        vecs.push_back(v);
    endtask

    task automatic chk(input string name, input logic [13:0] act, input logic [13:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end else begin
            $display("ok   %s: %h", name, act);
        end
    endtask

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int found;
        int done_at;
        bit saw_done;

        // A: encrypt, plain
        add(1, 0, 0, exp_busy(0, 0, 10));
        for (int k = 1; k <= 10; k++) add(0, 0, 0, exp_busy(k, 0, 10));
        add(0, 0, 0, EXP_DONE);
        add(0, 0, 0, EXP_IDLE);
        // B: decrypt, Mode toggling while busy
        add(1, 1, 0, exp_busy(0, 1, 10));
        for (int k = 1; k <= 10; k++) add(0, bit'(k % 2), 0, exp_busy(k, 1, 10));
        add(0, 0, 0, EXP_DONE);
        add(0, 0, 0, EXP_IDLE);
        // C: encrypt with 3 Hold cycles at index 4, stray Start/Mode during busy
        add(1, 0, 0, exp_busy(0, 0, 10));
        for (int k = 1; k <= 4; k++) add(0, 0, 0, exp_busy(k, 0, 10));
        for (int i = 0; i < 3; i++) add(1, bit'(i % 2), 1, exp_busy(4, 0, 10));
        for (int k = 5; k <= 10; k++) add(bit'(k == 7), 1, 0, exp_busy(k, 0, 10));
        add(0, 0, 0, EXP_DONE);
        // D: back-to-back decrypt started in the Done cycle (Hold ignored there),
        //    then Hold in INIT and in FINAL
        add(1, 1, 1, exp_busy(0, 1, 10));
        add(0, 1, 1, exp_busy(0, 1, 10));
        for (int k = 1; k <= 10; k++) add(0, 0, 0, exp_busy(k, 1, 10));
        add(0, 0, 1, exp_busy(10, 1, 10));
        add(0, 0, 0, EXP_DONE);
        add(0, 0, 1, EXP_IDLE);

        // Reset state
        step();
        step();
        chk("reset_nr10", out10(), EXP_IDLE);
        chk("reset_nr14", out14(), EXP_IDLE);
        Rst = 1'b0;
        step();
        chk("idle_after_reset", out10(), EXP_IDLE);

        for (int i = 0; i < vecs.size(); i++) begin
            Start = vecs[i].start;
            Mode  = vecs[i].mode;
            Hold  = vecs[i].hold;
            step();
            chk($sformatf("vec%0d", i), out10(), vecs[i].exp);
        end
        Start = 1'b0;
        Mode  = 1'b0;
        Hold  = 1'b0;
        for (int i = 0; i < 20; i++) step();

        // Asynchronous reset while SelKeyEnc=6
        Start = 1'b1;
        step();
        Start = 1'b0;
        found = 0;
        for (int i = 0; i < 20 && found == 0; i++) begin
            if (busy10 && se10 == 4'd6) found = 1;
            else step();
        end
        chk("reach_idx6", {13'b0, se10 == 4'd6}, 14'h0001);
        #2;
        Rst = 1'b1;
        #1;
        chk("async_rst_nr10", out10(), EXP_IDLE);
        chk("async_rst_nr14", out14(), EXP_IDLE);
        step();
        Rst = 1'b0;
        saw_done = 1'b0;
        for (int i = 0; i < 15; i++) begin
            step();
            if (done10) saw_done = 1'b1;
        end
        chk("no_done_after_abort", {13'b0, saw_done}, EXP_IDLE);

        // Fresh run after reset: Done at t+12
        Start = 1'b1;
        step();
        Start = 1'b0;
        chk("restart_init", out10(), exp_busy(0, 0, 10));
        done_at = 0;
        for (int n = 2; n <= 30 && done_at == 0; n++) begin
            step();
            if (done10) done_at = n;
        end
        chk("restart_done_latency", 14'(done_at), 14'd12);
        for (int i = 0; i < 20; i++) step();

        // NR=14 encrypt then decrypt
        for (int m = 0; m < 2; m++) begin
            Mode  = bit'(m);
            Start = 1'b1;
            step();
            Start = 1'b0;
            chk($sformatf("nr14_m%0d_k0", m), out14(), exp_busy(0, bit'(m), 14));
            for (int k = 1; k <= 14; k++) begin
                step();
                chk($sformatf("nr14_m%0d_k%0d", m, k), out14(), exp_busy(k, bit'(m), 14));
            end
            step();
            chk($sformatf("nr14_m%0d_done", m), out14(), EXP_DONE);
            step();
            chk($sformatf("nr14_m%0d_idle", m), out14(), EXP_IDLE);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
